// File: rtl/sprite_pkg.sv
// ============================================================================
// sprite_pkg: shared types and constants for the sprite commit scheduler.
// Rev 1.0
// ============================================================================
`default_nettype none

package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [4:0] ADDR_STATUS = 5'h1E;
    localparam logic [4:0] ADDR_CTRL   = 5'h1F;

    localparam int X_W = 11;
    localparam int Y_W = 10;

endpackage

`default_nettype wire

// File: rtl/sprite_slot.sv
// ============================================================================
// sprite_slot: pending/effective position registers and valid flags of one sprite.
// Rev 1.0
// ============================================================================
`default_nettype none

module sprite_slot
    import sprite_pkg::*;
#(
    parameter int RESET_X = 100,
    parameter int RESET_Y = 100
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           wr_x,
    input  logic           wr_y,
    input  logic [X_W-1:0] x_data,
    input  logic [Y_W-1:0] y_data,
    input  logic           commit_en,
    output logic [X_W-1:0] x_eff,
    output logic [Y_W-1:0] y_eff,
    output logic           x_v,
    output logic           y_v
);

    logic [X_W-1:0] x_pend;
    logic [Y_W-1:0] y_pend;
    logic           commit;

    // Only a fully specified position moves; a half-written one waits.
    assign commit = commit_en && x_v && y_v;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_eff  <= X_W'(RESET_X);
            y_eff  <= Y_W'(RESET_Y);
            x_pend <= X_W'(RESET_X);
            y_pend <= Y_W'(RESET_Y);
            x_v    <= 1'b0;
            y_v    <= 1'b0;
        end else begin
            if (commit) begin
                x_eff <= x_pend;
                y_eff <= y_pend;
            end
            // A bus write landing on the commit cycle keeps its flag set.
            if (wr_x) begin
                x_pend <= x_data;
                x_v    <= 1'b1;
            end else if (commit) begin
                x_v <= 1'b0;
            end
            if (wr_y) begin
                y_pend <= y_data;
                y_v    <= 1'b1;
            end else if (commit) begin
                y_v <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sprite_commit_sched.sv
// ============================================================================
// sprite_commit_sched: bus-written sprite positions committed once per frame
// at vertical blanking. Optional commit-done irq via SPRITE_COMMIT_IRQ_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module sprite_commit_sched
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int VACTIVE     = 480,
    parameter int RESET_X     = 100,
    parameter int RESET_Y     = 100
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       chipselect,
    input  logic                       write,
    input  logic                       read,
    input  logic [4:0]                 address,
    input  logic [15:0]                writedata,
    output logic [15:0]                readdata,
    input  logic [10:0]                hcount,
    input  logic [9:0]                 vcount,
    output logic [NUM_SPRITES*X_W-1:0] sprite_x_eff,
    output logic [NUM_SPRITES*Y_W-1:0] sprite_y_eff,
    output logic                       commit_busy,
    output logic                       irq
);

    localparam logic [3:0] IDX_LAST = 4'(NUM_SPRITES - 1);

    state_t                 state;
    logic [3:0]             idx;
    logic [7:0]             frame_cnt;
    logic                   freeze;
    logic                   bus_wr;
    logic                   bus_rd;
    logic                   vblank_start;
    logic                   pend_any;
    logic [15:0]            rd_val;
    logic [NUM_SPRITES-1:0] wr_x;
    logic [NUM_SPRITES-1:0] wr_y;
    logic [NUM_SPRITES-1:0] commit_en;
    logic [NUM_SPRITES-1:0] x_v;
    logic [NUM_SPRITES-1:0] y_v;
    logic                   unused_bits;

    assign bus_wr       = chipselect && write;
    assign bus_rd       = chipselect && read;
    assign vblank_start = (vcount == 10'(VACTIVE)) && (hcount == 11'd0);
    assign commit_busy  = (state != IDLE);
    assign pend_any     = |(x_v & y_v);
    assign unused_bits  = &{1'b0, writedata[15:11]};

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
        assign wr_x[i]      = bus_wr && (address == 5'(2 * i));
        assign wr_y[i]      = bus_wr && (address == 5'(2 * i + 1));
        assign commit_en[i] = (state == COMMIT) && (idx == 4'(i));

        sprite_slot #(
            .RESET_X (RESET_X),
            .RESET_Y (RESET_Y)
        ) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr_x      (wr_x[i]),
            .wr_y      (wr_y[i]),
            .x_data    (writedata[X_W-1:0]),
            .y_data    (writedata[Y_W-1:0]),
            .commit_en (commit_en[i]),
            .x_eff     (sprite_x_eff[X_W*i +: X_W]),
            .y_eff     (sprite_y_eff[Y_W*i +: Y_W]),
            .x_v       (x_v[i]),
            .y_v       (y_v[i])
        );
    end

    always_comb begin
        rd_val = 16'd0;
        if (address == ADDR_STATUS) begin
            rd_val = {frame_cnt, 2'b00, freeze, commit_busy, 3'b000, pend_any};
        end else if (address == ADDR_CTRL) begin
            rd_val = {15'd0, freeze};
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (address == 5'(2 * i))
                    rd_val = {{(16 - X_W){1'b0}}, sprite_x_eff[X_W*i +: X_W]};
                if (address == 5'(2 * i + 1))
                    rd_val = {{(16 - Y_W){1'b0}}, sprite_y_eff[Y_W*i +: Y_W]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= 4'd0;
            frame_cnt <= 8'd0;
            freeze    <= 1'b0;
            readdata  <= 16'd0;
        end else begin
            if (bus_wr && (address == ADDR_CTRL))
                freeze <= writedata[0];
            if (bus_rd)
                readdata <= rd_val;
            case (state)
                IDLE: begin
                    if (vblank_start && !freeze) begin
                        idx   <= 4'd0;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (idx == IDX_LAST)
                        state <= DONE;
                    else
                        idx <= idx + 4'd1;
                end
                DONE: begin
                    frame_cnt <= frame_cnt + 8'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPRITE_COMMIT_IRQ_EN
    logic irq_q;

    // Set wins over a coincident STATUS-read clear.
    always_ff @(posedge clk) begin
        if (!reset_n)
            irq_q <= 1'b0;
        else if (state == DONE)
            irq_q <= 1'b1;
        else if (bus_rd && (address == ADDR_STATUS))
            irq_q <= 1'b0;
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

`default_nettype wire
